// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and byte bit-order helper.
// No latency (constants and a pure function).
// No flow control involved.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Swap bit order so the first serial bit (received in bit 7) lands in bit 0.
  function automatic logic [UART_DATA_W-1:0] bit_reverse8(input logic [UART_DATA_W-1:0] d);
    logic [UART_DATA_W-1:0] r;
    for (int i = 0; i < UART_DATA_W; i++) begin
      r[i] = d[UART_DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with an occupancy counter and a drop indication.
// Push visible at pop_data one edge after write; pop_data is combinational from storage.
// A push while full is accepted only with a same-cycle pop; otherwise drop pulses.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_fire;
  logic              push_ok;

  assign empty    = (level == '0);
  assign full     = (level == LVL_FULL);
  assign pop_fire = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign push_ok  = push & (~full | pop_fire);
  assign drop     = push & full & ~pop_fire;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally; level tracks occupancy independently of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_fire) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_fire})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one write per rx_done high period, optional bit reversal, sticky overrun.
// rd_valid/rd_data appear one edge after rx_done is first sampled high; reads are same-cycle.
// Bytes arriving while full with no read are dropped and flag overrun; read side is valid/ready.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [UART_DATA_W-1:0]   rx_data,
  input  logic                     rx_done,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [UART_DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  logic                   done_q;
  logic                   wr_stb;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   fifo_empty;
  logic                   fifo_drop;

  // done_q resets low so a done already high at reset release still yields one write.
  assign wr_stb  = rx_done & ~done_q;
  assign wr_data = BIT_REVERSE ? bit_reverse8(rx_data) : rx_data;
  assign rd_valid = ~fifo_empty;

  // Remember previous rx_done to find its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= rx_done;
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overrun <= 1'b0;
    else if (fifo_drop)   overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  uart_sync_fifo #(
    .DATA_W (UART_DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_stb),
    .push_data (wr_data),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .level     (level),
    .full      (full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rd_ready;
  logic          clr_overrun;
  logic          rd_valid, full, overrun;
  logic [7:0]    rd_data;
  logic [LW-1:0] level;
  logic          rd_valid_n, full_n, overrun_n;
  logic [7:0]    rd_data_n;
  logic [LW-1:0] level_n;

  int nchk = 0;
  int nerr = 0;

  // Reference state: byte queues (reversed and raw), sticky flag, last done level.
  logic [7:0] q_rev[$];
  logic [7:0] q_raw[$];
  bit         m_ovr;
  bit         m_prev_done;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .BIT_REVERSE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level), .full(full), .overrun(overrun), .clr_overrun(clr_overrun));

  uart_rx_fifo #(.DEPTH(DEPTH), .BIT_REVERSE(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .rd_ready(rd_ready), .rd_valid(rd_valid_n), .rd_data(rd_data_n),
    .level(level_n), .full(full_n), .overrun(overrun_n), .clr_overrun(clr_overrun));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  task automatic model_reset();
    q_rev.delete();
    q_raw.delete();
    m_ovr = 1'b0;
    m_prev_done = 1'b0;
  endtask

  task automatic check_outputs();
    check("rd_valid", rd_valid, q_rev.size() != 0);
    check("level", level, q_rev.size());
    check("full", full, q_rev.size() == DEPTH);
    check("overrun", overrun, m_ovr);
    check("nr_level", level_n, q_raw.size());
    check("nr_rd_valid", rd_valid_n, q_raw.size() != 0);
    check("nr_full", full_n, q_raw.size() == DEPTH);
    check("nr_overrun", overrun_n, m_ovr);
    if (q_rev.size() != 0) begin
      check("rd_data", rd_data, q_rev[0]);
      check("nr_rd_data", rd_data_n, q_raw[0]);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic step(input logic done, input logic [7:0] d, input logic rdy, input logic clr);
    bit wr, fire, was_full, dropped;
    rx_done = done; rx_data = d; rd_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    wr       = done && !m_prev_done;
    fire     = rdy && q_rev.size() != 0;
    was_full = q_rev.size() == DEPTH;
    dropped  = wr && was_full && !fire;
    if (fire) begin
      void'(q_rev.pop_front());
      void'(q_raw.pop_front());
    end
    if (wr && !dropped) begin
      q_rev.push_back(rev(d));
      q_raw.push_back(d);
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_prev_done = done;
    #1;
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic rdy);
    step(1'b1, d, rdy, 1'b0);
    step(1'b0, d, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_level", level, 0);
    check("rst_full", full, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;

    // Long done pulse: exactly one write, LSB-first 0x80 -> 0x01.
    step(1'b0, 8'h80, 1'b0, 1'b0);
    step(1'b1, 8'h80, 1'b0, 1'b0);
    check("single_data", rd_data, 8'h01);
    for (int i = 0; i < 15; i++) step(1'b1, 8'h80, 1'b0, 1'b0);
    check("single_level", level, 1);
    check("single_raw", rd_data_n, 8'h80);
    step(1'b0, 8'h80, 1'b0, 1'b0);
    drain();

    // Palindrome and reversal pattern.
    send_byte(8'hA5, 1'b0);
    check("a5_rev", rd_data, 8'hA5);
    check("a5_raw", rd_data_n, 8'hA5);
    drain();
    send_byte(8'hC0, 1'b0);
    check("c0_rev", rd_data, 8'h03);
    check("c0_raw", rd_data_n, 8'hC0);
    drain();

    // Fill beyond capacity: byte 16 dropped, order preserved.
    for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b0);
    check("fill_full", full, 1'b1);
    check("fill_level", level, DEPTH);
    check("fill_overrun", overrun, 1'b1);
    drain();

    // Clear alone.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_alone", overrun, 1'b0);

    // Full with simultaneous read and write.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h40 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("rw_full_ovr", overrun, 1'b0);
    check("rw_full_level", level, DEPTH);
    step(1'b0, 8'hEE, 1'b0, 1'b0);

    // Drop coinciding with clear: set wins.
    step(1'b1, 8'h11, 1'b0, 1'b1);
    check("clr_vs_drop", overrun, 1'b1);
    step(1'b0, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_level", level, 5);

    // Async reset mid-cycle.
    #2 rst_n = 1'b0;
    rx_done = 1'b1; rx_data = 8'h3C;
    #1;
    check("arst_rd_valid", rd_valid, 1'b0);
    check("arst_level", level, 0);
    check("arst_full", full, 1'b0);
    check("arst_overrun", overrun, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_rst_level", level, 1);
    check("post_rst_data", rd_data, 8'h3C);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 15) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
